one_counter_fsm: RTL

ONE_COUNTER_FSM -- requirements
Module: one_counter_fsm

---
 rtl/one_counter_fsm.sv | 107 ++++++++++
 1 files changed

// File: rtl/one_counter_fsm.sv
// Bit-serial population counter. It loads a word, shifts it out LSB first over N cycles
// and accumulates the set bits, then pulses o_done for one cycle with the result.

module mux2 #(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

module one_counter_fsm #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [N-1:0]  i_data,
  output logic          o_busy,
  output logic          o_done,
  output logic [CW-1:0] o_count
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          last;
  logic [N-1:0]  sreg;
  logic [N-1:0]  sreg_shr;
  logic [N-1:0]  sreg_nxt;
  logic [CW-1:0] acc;
  logic [CW-1:0] sum;
  logic [CW-1:0] bitcnt;

  // A start request is taken in every state except SHIFT.
  assign accept   = i_start && (state != SHIFT);
  assign last     = (state == SHIFT) && (bitcnt == '0);
  assign sreg_shr = sreg >> 1;
  assign sum      = acc + {{(CW-1){1'b0}}, sreg[0]};

  mux2 #(.W(N)) u_sreg_mux (
    .sel (accept),
    .a   (sreg_shr),
    .b   (i_data),
    .y   (sreg_nxt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = SHIFT;
      end
      SHIFT: begin
        o_busy = 1'b1;
        if (bitcnt == '0) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = i_start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sreg    <= '0;
      acc     <= '0;
      bitcnt  <= '0;
      o_count <= '0;
    end else if (accept) begin
      sreg   <= sreg_nxt;
      acc    <= '0;
      bitcnt <= CW'(N - 1);
    end else if (state == SHIFT) begin
      sreg <= sreg_nxt;
      acc  <= sum;
      if (last) begin
        o_count <= sum;
      end else begin
        bitcnt <= bitcnt - CW'(1);
      end
    end
  end

endmodule
